// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - three-wide instruction fetch sequencer with redirect and backpressure handling
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          OCC_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 redirect_valid_i,
    input  logic [31:0]          redirect_pc_i,
    input  logic                 ibuf_ready_i,
    input  logic [OCC_WIDTH-1:0] ibuf_occupancy_i,
    output logic                 imem_req_o,
    output logic [31:0]          imem_addr_o,
    input  logic                 imem_gnt_i,
    input  logic                 imem_rvalid_i,
    input  logic [95:0]          imem_rdata_i,
    output logic [2:0]           fetch_valid_o,
    output logic [31:0]          instruction_o_0,
    output logic [31:0]          instruction_o_1,
    output logic [31:0]          instruction_o_2,
    output logic [31:0]          pc_o_0,
    output logic [31:0]          pc_o_1,
    output logic [31:0]          pc_o_2,
    output logic                 ibuf_flush_o,
    output logic [15:0]          stall_count_o
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_fetch_pc;
    logic [31:0] r_grp_pc;
    logic [95:0] r_hold_data;
    logic [15:0] r_stall_count;

    logic        w_req;
    logic        w_grant;
    logic        w_present_rdata;
    logic        w_present_hold;
    logic        w_capture_hold;
    logic        w_fetch_valid;
    logic [95:0] w_out_data;
    logic        w_stall_inc;
    logic        w_unused;

    // Occupancy is monitor-only and redirect targets are word aligned, so these bits are intentionally dropped.
    assign w_unused = ^{ibuf_occupancy_i, redirect_pc_i[1:0]};

    // State register; reset abandons any outstanding request by returning to REQ.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_REQ;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and per-cycle action decode; a redirect always overrides delivery and requests.
    always_comb begin
        w_next_state    = r_state;
        w_req           = 1'b0;
        w_grant         = 1'b0;
        w_present_rdata = 1'b0;
        w_present_hold  = 1'b0;
        w_capture_hold  = 1'b0;
        case (r_state)
            ST_REQ: begin
                w_req = ibuf_ready_i && !redirect_valid_i;
                if (w_req && imem_gnt_i) begin
                    w_grant      = 1'b1;
                    w_next_state = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (redirect_valid_i) begin
                    // A response landing with the redirect is stale and can be dropped immediately.
                    w_next_state = imem_rvalid_i ? ST_REQ : ST_DRAIN;
                end else if (imem_rvalid_i) begin
                    if (ibuf_ready_i) begin
                        w_present_rdata = 1'b1;
                        w_next_state    = ST_REQ;
                    end else begin
                        w_capture_hold = 1'b1;
                        w_next_state   = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (redirect_valid_i) begin
                    w_next_state = ST_REQ;
                end else if (ibuf_ready_i) begin
                    w_present_hold = 1'b1;
                    w_next_state   = ST_REQ;
                end
            end
            ST_DRAIN: begin
                if (!redirect_valid_i && imem_rvalid_i) begin
                    w_next_state = ST_REQ;
                end
            end
            default: begin
                w_next_state = ST_REQ;
            end
        endcase
    end

    assign w_stall_inc = ((r_state == ST_REQ) && !ibuf_ready_i && !redirect_valid_i) ||
                         ((r_state == ST_HOLD) && !ibuf_ready_i);

    // Fetch address, group PC and parked response registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fetch_pc  <= RESET_PC;
            r_grp_pc    <= 32'h0000_0000;
            r_hold_data <= 96'h0;
        end else begin
            if (redirect_valid_i) begin
                r_fetch_pc <= {redirect_pc_i[31:2], 2'b00};
            end else if (w_grant) begin
                r_grp_pc   <= r_fetch_pc;
                r_fetch_pc <= r_fetch_pc + 32'd12;
            end
            if (w_capture_hold) begin
                r_hold_data <= imem_rdata_i;
            end
        end
    end

    // Saturating backpressure counter; only reset clears it, redirects do not.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_count <= 16'h0000;
        end else if (w_stall_inc && (r_stall_count != 16'hFFFF)) begin
            r_stall_count <= r_stall_count + 16'd1;
        end
    end

    assign w_fetch_valid = w_present_rdata || w_present_hold;
    assign w_out_data    = w_present_hold ? r_hold_data : imem_rdata_i;

    assign imem_req_o      = w_req && reset;
    assign imem_addr_o     = r_fetch_pc;
    assign ibuf_flush_o    = redirect_valid_i;
    assign stall_count_o   = r_stall_count;
    assign fetch_valid_o   = w_fetch_valid ? 3'b111 : 3'b000;
    assign instruction_o_0 = w_fetch_valid ? w_out_data[31:0]  : NOP;
    assign instruction_o_1 = w_fetch_valid ? w_out_data[63:32] : NOP;
    assign instruction_o_2 = w_fetch_valid ? w_out_data[95:64] : NOP;
    assign pc_o_0          = w_fetch_valid ? r_grp_pc          : 32'h0000_0000;
    assign pc_o_1          = w_fetch_valid ? r_grp_pc + 32'd4  : 32'h0000_0000;
    assign pc_o_2          = w_fetch_valid ? r_grp_pc + 32'd8  : 32'h0000_0000;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - scoreboard testbench for fetch_sequencer
module tb_fetch_sequencer;

    logic        clk;
    logic        reset;
    logic        redirect_valid_i;
    logic [31:0] redirect_pc_i;
    logic        ibuf_ready_i;
    logic [3:0]  ibuf_occupancy_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [95:0] imem_rdata_i;
    logic [2:0]  fetch_valid_o;
    logic [31:0] instruction_o_0, instruction_o_1, instruction_o_2;
    logic [31:0] pc_o_0, pc_o_1, pc_o_2;
    logic        ibuf_flush_o;
    logic [15:0] stall_count_o;

    fetch_sequencer dut (
        .clk              (clk),
        .reset            (reset),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .ibuf_ready_i     (ibuf_ready_i),
        .ibuf_occupancy_i (ibuf_occupancy_i),
        .imem_req_o       (imem_req_o),
        .imem_addr_o      (imem_addr_o),
        .imem_gnt_i       (imem_gnt_i),
        .imem_rvalid_i    (imem_rvalid_i),
        .imem_rdata_i     (imem_rdata_i),
        .fetch_valid_o    (fetch_valid_o),
        .instruction_o_0  (instruction_o_0),
        .instruction_o_1  (instruction_o_1),
        .instruction_o_2  (instruction_o_2),
        .pc_o_0           (pc_o_0),
        .pc_o_1           (pc_o_1),
        .pc_o_2           (pc_o_2),
        .ibuf_flush_o     (ibuf_flush_o),
        .stall_count_o    (stall_count_o)
    );

    typedef struct packed {
        logic [31:0] pc0, pc1, pc2;
        logic [31:0] i0, i1, i2;
    } grp_t;

    grp_t        exp_grp[$];
    logic [31:0] exp_addr[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic        mon_en   = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic fail_event(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s actual=event expected=none", name);
    endtask

    function automatic grp_t mk_grp(input logic [31:0] p0, input logic [31:0] p1, input logic [31:0] p2,
                                    input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2);
        grp_t g;
        g.pc0 = p0; g.pc1 = p1; g.pc2 = p2;
        g.i0 = w0;  g.i1 = w1;  g.i2 = w2;
        return g;
    endfunction

    task automatic drive(input logic rd, input logic [31:0] rpc, input logic rdy,
                         input logic gnt, input logic rv, input logic [95:0] data);
        redirect_valid_i = rd;
        redirect_pc_i    = rpc;
        ibuf_ready_i     = rdy;
        imem_gnt_i       = gnt;
        imem_rvalid_i    = rv;
        imem_rdata_i     = data;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic rd, input logic [31:0] rpc, input logic rdy,
                        input logic gnt, input logic rv, input logic [95:0] data);
        drive(rd, rpc, rdy, gnt, rv, data);
        tick();
    endtask

    // Monitor: sample away from the rising edge, pop expectations on handshakes and deliveries.
    always @(negedge clk) begin
        if (mon_en) begin
            check("flush_eq_redirect", ibuf_flush_o, redirect_valid_i);
            if (imem_req_o)
                check("req_only_when_ready", {ibuf_ready_i, redirect_valid_i}, 2'b10);
            if (imem_req_o && imem_gnt_i) begin
                if (exp_addr.size() == 0) fail_event("unexpected_request");
                else check("req_addr", imem_addr_o, exp_addr.pop_front());
            end
            if (fetch_valid_o != 3'b000) begin
                if (exp_grp.size() == 0) begin
                    fail_event("unexpected_fetch");
                end else begin
                    grp_t g;
                    g = exp_grp.pop_front();
                    check("fetch_valid", fetch_valid_o, 3'b111);
                    check("fetch_pcs", {pc_o_0, pc_o_1, pc_o_2}, {g.pc0, g.pc1, g.pc2});
                    check("fetch_instr", {instruction_o_0, instruction_o_1, instruction_o_2}, {g.i0, g.i1, g.i2});
                end
            end else begin
                check("idle_instr_nop", {instruction_o_0, instruction_o_1, instruction_o_2}, {3{32'h0000_0013}});
                check("idle_pc_zero", {pc_o_0, pc_o_1, pc_o_2}, 96'h0);
            end
        end
    end

    // Directed stimulus; expected groups and addresses are queued before the cycle that produces them.
    initial begin
        reset = 1'b0;
        ibuf_occupancy_i = 4'd0;
        drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 96'h0);
        repeat (3) @(posedge clk);
        #2;
        check("reset_req", imem_req_o, 1'b0);
        check("reset_valid", fetch_valid_o, 3'b000);
        check("reset_stall", stall_count_o, 16'h0);
        check("reset_addr", imem_addr_o, 32'h0);
        @(posedge clk);
        #1;
        reset  = 1'b1;
        mon_en = 1'b1;

        // Back-to-back fetch with immediate responses.
        exp_addr.push_back(32'h0000_0000); step(0, 0, 1, 1, 0, 96'h0);
        exp_grp.push_back(mk_grp(32'h0, 32'h4, 32'h8, 32'h11, 32'h22, 32'h33));
        step(0, 0, 1, 1, 1, {32'h33, 32'h22, 32'h11});
        exp_addr.push_back(32'h0000_000C); step(0, 0, 1, 1, 0, 96'h0);
        exp_grp.push_back(mk_grp(32'hC, 32'h10, 32'h14, 32'h44, 32'h55, 32'h66));
        step(0, 0, 1, 1, 1, {32'h66, 32'h55, 32'h44});
        exp_addr.push_back(32'h0000_0018); step(0, 0, 1, 1, 0, 96'h0);

        // Response parked while the buffer is full for three cycles.
        step(0, 0, 0, 1, 1, {32'h99, 32'h88, 32'h77});
        repeat (3) step(0, 0, 0, 1, 0, 96'h0);
        check("hold_stall_count", stall_count_o, 16'd3);
        exp_grp.push_back(mk_grp(32'h18, 32'h1C, 32'h20, 32'h77, 32'h88, 32'h99));
        step(0, 0, 1, 1, 0, 96'h0);

        // Redirect while waiting, stale response drained later.
        exp_addr.push_back(32'h0000_0024); step(0, 0, 1, 1, 0, 96'h0);
        drive(1, 32'h0000_1002, 1, 1, 0, 96'h0);
        #1;
        check("redirect_flush", ibuf_flush_o, 1'b1);
        check("redirect_no_req", imem_req_o, 1'b0);
        tick();
        drive(0, 0, 1, 1, 0, 96'h0);
        #1;
        check("drain_no_req", imem_req_o, 1'b0);
        tick();
        step(0, 0, 1, 1, 1, {32'hDEAD, 32'hBEEF, 32'hCAFE});
        exp_addr.push_back(32'h0000_1000); step(0, 0, 1, 1, 0, 96'h0);

        // Redirect and response in the same waiting cycle.
        drive(1, 32'h0000_2000, 1, 1, 1, {32'hBAD2, 32'hBAD1, 32'hBAD0});
        #1;
        check("redirect_rvalid_no_fetch", fetch_valid_o, 3'b000);
        tick();
        exp_addr.push_back(32'h0000_2000); step(0, 0, 1, 1, 0, 96'h0);
        exp_grp.push_back(mk_grp(32'h2000, 32'h2004, 32'h2008, 32'hA0, 32'hA1, 32'hA2));
        step(0, 0, 1, 1, 1, {32'hA2, 32'hA1, 32'hA0});

        // Redirect discards a parked group; unaligned target is word-aligned.
        exp_addr.push_back(32'h0000_200C); step(0, 0, 1, 1, 0, 96'h0);
        step(0, 0, 0, 1, 1, {32'hC2, 32'hC1, 32'hC0});
        step(1, 32'hFFFF_FFFB, 1, 1, 0, 96'h0);

        // Address wrap-around past 2^32.
        exp_addr.push_back(32'hFFFF_FFF8); step(0, 0, 1, 1, 0, 96'h0);
        exp_grp.push_back(mk_grp(32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'hB0, 32'hB1, 32'hB2));
        step(0, 0, 1, 1, 1, {32'hB2, 32'hB1, 32'hB0});
        step(0, 0, 1, 0, 1, {32'hE2, 32'hE1, 32'hE0});
        exp_addr.push_back(32'h0000_0004); step(0, 0, 1, 1, 0, 96'h0);
        exp_grp.push_back(mk_grp(32'h4, 32'h8, 32'hC, 32'hD0, 32'hD1, 32'hD2));
        step(0, 0, 1, 1, 1, {32'hD2, 32'hD1, 32'hD0});
        check("stall_after_redirects", stall_count_o, 16'd3);

        // Long backpressure in REQ: counter saturates, no requests.
        repeat (100) step(0, 0, 0, 1, 0, 96'h0);
        check("stall_count_103", stall_count_o, 16'd103);
        repeat (69900) step(0, 0, 0, 1, 0, 96'h0);
        check("stall_saturated", stall_count_o, 16'hFFFF);
        exp_addr.push_back(32'h0000_0010); step(0, 0, 1, 1, 0, 96'h0);
        check("stall_held_at_max", stall_count_o, 16'hFFFF);

        // Reset with a request outstanding.
        drive(0, 0, 1, 1, 0, 96'h0);
        reset = 1'b0;
        #1;
        check("midreset_stall", stall_count_o, 16'h0);
        check("midreset_req", imem_req_o, 1'b0);
        check("midreset_addr", imem_addr_o, 32'h0);
        tick();
        reset = 1'b1;
        exp_addr.push_back(32'h0000_0000); step(0, 0, 1, 1, 0, 96'h0);
        exp_grp.push_back(mk_grp(32'h0, 32'h4, 32'h8, 32'hF0, 32'hF1, 32'hF2));
        step(0, 0, 1, 1, 1, {32'hF2, 32'hF1, 32'hF0});
        repeat (2) step(0, 0, 1, 0, 0, 96'h0);

        mon_en = 1'b0;
        check("addr_queue_drained", exp_addr.size(), 0);
        check("grp_queue_drained", exp_grp.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 The parameter list SHALL be exactly as follows (one per line: name, default, meaning):
  RESET_PC, 32'h0000_0000, first fetch address after reset.
  OCC_WIDTH, 4, width of the buffer occupancy input (depth 8 -> 4 bits).
REQ-002 The ports SHALL be exactly as follows (one per line: name, direction, width, meaning):
  clk  in  1  clock, rising edge.
  reset  in  1  asynchronous, active-low reset.
  redirect_valid_i  in  1  branch-mispredict or exception redirect.
  redirect_pc_i  in  32  redirect target.
  ibuf_ready_i  in  1  instruction buffer can accept 3 entries.
  ibuf_occupancy_i  in  OCC_WIDTH  buffer occupancy; monitor only.
  imem_req_o  out  1  instruction memory request.
  imem_addr_o  out  32  request address for a 12-byte group.
  imem_gnt_i  in  1  request accepted.
  imem_rvalid_i  in  1  response valid.
  imem_rdata_i  in  96  three words; word n is [32n+31:32n].
  fetch_valid_o  out  3  per-slot write valid to the buffer.
  instruction_o_0/1/2  out  32 each  fetched words.
  pc_o_0/1/2  out  32 each  PC of each slot.
  ibuf_flush_o  out  1  buffer flush.
  stall_count_o  out  16  saturating backpressure-stall counter.

Function
REQ-003 The FSM SHALL have exactly four states: REQ (may issue a request), WAIT (one request outstanding), HOLD (response parked), DRAIN (stale response pending).
REQ-004 At most one memory request SHALL be outstanding at any time.
REQ-005 In REQ, imem_req_o SHALL equal ibuf_ready_i && !redirect_valid_i, and imem_addr_o SHALL equal fetch_pc.
  The request may be withdrawn before grant.
REQ-006 When REQ sees imem_req_o && imem_gnt_i, the block SHALL latch grp_pc = fetch_pc, set fetch_pc = fetch_pc + 12 (modulo 2^32) and move to WAIT.
REQ-007 In WAIT, on imem_rvalid_i with ibuf_ready_i=1, the block SHALL drive the response in the same cycle and return to REQ:
  fetch_valid_o = 3'b111.
  instruction_o_n = rdata word n.
  pc_o_n = grp_pc + 4n.
REQ-008 In WAIT, on imem_rvalid_i with ibuf_ready_i=0, the block SHALL capture rdata into hold registers and move to HOLD; fetch_valid_o SHALL be 0 that cycle.
REQ-009 In HOLD, fetch_valid_o SHALL be 0 while ibuf_ready_i=0.
  On the first cycle with ibuf_ready_i=1, it SHALL present the held group with fetch_valid_o = 3'b111 for exactly one cycle, then move to REQ.
REQ-010 Whenever fetch_valid_o = 0, instruction_o_n SHALL be 32'h0000_0013 (NOP) and pc_o_n SHALL be 0.
REQ-011 ibuf_flush_o SHALL equal redirect_valid_i combinationally.
  In a redirect cycle, fetch_valid_o SHALL be 0 and imem_req_o SHALL be 0.
REQ-012 On a redirect, fetch_pc SHALL load {redirect_pc_i[31:2], 2'b00}, and the next state SHALL be:
  from REQ -> REQ.
  from HOLD -> REQ; held data discarded.
  from WAIT without imem_rvalid_i -> DRAIN.
  from WAIT with imem_rvalid_i in the same cycle -> REQ; response discarded.
  from DRAIN -> DRAIN.
REQ-013 In DRAIN, imem_req_o SHALL be 0 and fetch_valid_o SHALL be 0. On imem_rvalid_i, the response SHALL be discarded and the state SHALL move to REQ, unless a redirect occurs in that same cycle, in which case REQ-012 applies.
REQ-014 stall_count_o SHALL increment by 1 on each cycle with either (state REQ && !ibuf_ready_i && !redirect_valid_i) or (state HOLD && !ibuf_ready_i).
  It SHALL saturate at 16'hFFFF and SHALL NOT be cleared by a redirect.
REQ-015 imem_rvalid_i arriving in REQ SHALL be ignored.

Reset
REQ-016 While reset=0, the block SHALL hold:
  state = REQ.
  fetch_pc = RESET_PC; grp_pc = 0; hold registers = 0.
  stall_count_o = 0; fetch_valid_o = 0; imem_req_o = 0.
REQ-017 Assertion of reset mid-operation SHALL abandon any outstanding request. The first cycle after deassertion SHALL behave as REQ with fetch_pc = RESET_PC.

Verification
REQ-018 Scenario: after reset, ready=1, gnt=1 every cycle, rvalid one cycle after each grant.
  Required: addresses 0x0, 0xC, 0x18; first group pc_o = 0x0/0x4/0x8 with fetch_valid_o = 3'b111.
REQ-019 Scenario: rvalid arrives while ready=0, ready rises 3 cycles later.
  Required: fetch_valid_o = 0 for those 3 cycles, then the held words are presented for exactly 1 cycle; stall_count_o increments by 3.
REQ-020 Scenario: redirect to 0x1002 while in WAIT, then rvalid 2 cycles later.
  Required: ibuf_flush_o pulses; the response is discarded with no fetch_valid_o; the next request address is 0x1000.
REQ-021 Scenario: redirect and rvalid in the same WAIT cycle.
  Required: fetch_valid_o = 0, the next state is REQ, and the next address is the redirect target.
REQ-022 Scenario: fetch_pc = 0xFFFF_FFF8 is granted.
  Required: the next address is 0x0000_0004 (wrap-around); the group PCs are 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
REQ-023 Scenario: ready=0 for 70000 cycles in REQ.
  Required: stall_count_o saturates at 0xFFFF; no request is issued; a reset pulse returns the counter to 0.
